// File: rtl/pe_node_if.sv
// ============================================================================
//  Module   : pe_node_if
//  Brief    : NoC processing-element endpoint. Queues ingress flits, adds
//             DATA_INC to the payload and returns the result to the scheduler
//             node with the original packet number. Optional feature macro:
//             PE_ADDR_CHECK_EN (drop and count misaddressed flits).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pe_node_if #(
    parameter int X_SIZE      = 2,
    parameter int Y_SIZE      = 2,
    parameter int PCK_NUM     = 4,
    parameter int DATA_WIDTH  = 16,
    parameter int TOTAL_WIDTH = 24,
    parameter int X_COORD     = 1,
    parameter int Y_COORD     = 0,
    parameter int RET_X       = 0,
    parameter int RET_Y       = 0,
    parameter int FIFO_AW     = 2,
    parameter int PROC_CYCLES = 2,
    parameter int DATA_INC    = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_valid,
    input  logic [TOTAL_WIDTH-1:0] i_data,
    output logic                   o_ready,
    output logic                   o_valid,
    output logic [TOTAL_WIDTH-1:0] o_data,
    input  logic                   i_ready,
    output logic                   o_busy,
    output logic [7:0]             o_drop_cnt
);

    localparam int c_DEPTH    = 2 ** FIFO_AW;
    localparam int c_PCK_LSB  = X_SIZE + Y_SIZE;
    localparam int c_DATA_LSB = c_PCK_LSB + PCK_NUM;
    localparam int c_FIFO_W   = DATA_WIDTH + PCK_NUM;
    localparam int c_CNT_W    = (PROC_CYCLES > 1) ? $clog2(PROC_CYCLES) : 1;

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_COMPUTE = 2'd1;
    localparam logic [1:0] c_SEND    = 2'd2;

    logic [1:0]             r_state;
    logic [1:0]             w_state_nxt;
    logic [FIFO_AW:0]       r_wr_ptr;
    logic [FIFO_AW:0]       r_rd_ptr;
    logic [c_FIFO_W-1:0]    r_mem [c_DEPTH];
    logic [c_CNT_W-1:0]     r_cnt;
    logic [DATA_WIDTH-1:0]  r_work_data;
    logic [PCK_NUM-1:0]     r_work_pck;
    logic                   r_valid;
    logic [TOTAL_WIDTH-1:0] r_data;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_accept;
    logic                   w_addr_ok;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_load_out;
    logic                   w_send_done;
    logic [c_FIFO_W-1:0]    w_head;
    logic [DATA_WIDTH-1:0]  w_result;

    // Wrap bit distinguishes full from empty when the index bits match.
    assign w_empty  = (r_wr_ptr == r_rd_ptr);
    assign w_full   = (r_wr_ptr[FIFO_AW] != r_rd_ptr[FIFO_AW]) &&
                      (r_wr_ptr[FIFO_AW-1:0] == r_rd_ptr[FIFO_AW-1:0]);
    assign o_ready  = !w_full && !rst;
    assign w_accept = i_valid && o_ready;
    assign w_push   = w_accept && w_addr_ok;
    assign w_head   = r_mem[r_rd_ptr[FIFO_AW-1:0]];
    assign w_result = r_work_data + DATA_WIDTH'(DATA_INC);

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_busy  = (r_state != c_IDLE) || !w_empty;

`ifdef PE_ADDR_CHECK_EN
    logic [7:0] r_drop_cnt;

    assign w_addr_ok = (i_data[X_SIZE-1:0] == X_SIZE'(X_COORD)) &&
                       (i_data[X_SIZE +: Y_SIZE] == Y_SIZE'(Y_COORD));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop_cnt <= 8'd0;
        end else if (w_accept && !w_addr_ok && (r_drop_cnt != 8'hFF)) begin
            r_drop_cnt <= r_drop_cnt + 8'd1;
        end
    end

    assign o_drop_cnt = r_drop_cnt;
`else
    assign w_addr_ok  = 1'b1;
    assign o_drop_cnt = 8'd0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_load_out  = 1'b0;
        w_send_done = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = c_COMPUTE;
                end
            end
            c_COMPUTE: begin
                if (r_cnt == '0) begin
                    w_load_out  = 1'b1;
                    w_state_nxt = c_SEND;
                end
            end
            c_SEND: begin
                // r_valid is always set in SEND, so i_ready alone completes it.
                if (i_ready) begin
                    w_send_done = 1'b1;
                    if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_state_nxt = c_COMPUTE;
                    end else begin
                        w_state_nxt = c_IDLE;
                    end
                end
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // Storage array carries no reset; pointers alone define its contents.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[FIFO_AW-1:0]] <= i_data[TOTAL_WIDTH-1:c_PCK_LSB];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_cnt       <= '0;
            r_work_data <= '0;
            r_work_pck  <= '0;
            r_valid     <= 1'b0;
            r_data      <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr    <= r_rd_ptr + 1'b1;
                r_work_data <= w_head[c_FIFO_W-1 -: DATA_WIDTH];
                r_work_pck  <= w_head[PCK_NUM-1:0];
                r_cnt       <= c_CNT_W'(PROC_CYCLES - 1);
            end else if ((r_state == c_COMPUTE) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_load_out) begin
                r_valid <= 1'b1;
                r_data  <= {w_result, r_work_pck, Y_SIZE'(RET_Y), X_SIZE'(RET_X)};
            end else if (w_send_done) begin
                r_valid <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire
